cam_pixel_packer: RTL

Capture-side stage that sits directly upstream of the camera input FIFO (`FIFO_cam`, 17-bit words) feeding `VideoController`. It samples the OV7670 parallel bus (VSYNC/HREF/8-bit data), packs byte pairs into RGB565 pixels, and tags the first pixel of each frame in bit 16. It writes only whole, aligned frames: it starts at a VSYNC boundary, clips to FRAME_WIDTH×FRAME_HEIGHT, and drops the rest of a frame on FIFO overflow. It reports frame completion and sticky error status.

---
 rtl/cam_pixel_packer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cam_pixel_packer
// Purpose  : Samples the OV7670 parallel bus, packs byte pairs into RGB565
//            pixels and writes whole, aligned frames into the camera FIFO.
//            The first pixel of each frame is tagged in bit 16. Frames are
//            clipped to FRAME_WIDTH x FRAME_HEIGHT; a FIFO overflow drops
//            the rest of the frame. Frame completion and sticky error
//            status are reported.
// Ports    : clk          camera pixel clock (rising edge)
//            reset_p      asynchronous active-high reset
//            enable       capture permitted, sampled only while idle
//            cam_vsync    VSYNC, high during vertical blanking
//            cam_href     HREF, high while line bytes are valid
//            p_data       camera data byte
//            queue_full   FIFO full flag
//            err_clear    synchronous clear of overflow / geom_error
//            queue_data   {sof, R[4:0], G[5:0], B[4:0]}
//            queue_wr_en  one-cycle FIFO write strobe
//            frame_done   one-cycle pulse at the end of a captured frame
//            frame_count  completed frames, wraps 255 -> 0
//            overflow     sticky: write attempted while queue_full
//            geom_error   sticky: line or frame size mismatch
// Revision : 1.0  initial release
// ============================================================================
module cam_pixel_packer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  p_data,
    input  logic        queue_full,
    input  logic        err_clear,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        overflow,
    output logic        geom_error
);

    // x must represent FRAME_WIDTH+1 so an over-long line is distinguishable
    // from an exact one at the line check.
    localparam int              XW     = $clog2(FRAME_WIDTH + 2);
    localparam int              YW     = $clog2(FRAME_HEIGHT + 1);
    localparam logic [XW-1:0]   X_FULL = XW'(FRAME_WIDTH);
    localparam logic [XW-1:0]   X_CAP  = XW'(FRAME_WIDTH + 1);
    localparam logic [YW-1:0]   Y_FULL = YW'(FRAME_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // Input stage and edge-detect copies
    logic            vs_q, hr_q, vs_dly_q, hr_dly_q;
    logic [7:0]      d_q;

    // Byte pairing and position counters
    logic            phase_q;
    logic [7:0]      hi_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;

    // Output registers
    logic [16:0]     data_q;
    logic            wr_en_q, wr_en_d;
    logic            done_q, done_d;
    logic [7:0]      count_q, count_d;
    logic            ovf_q, geom_q;

    // Decode
    logic            vs_rise, vs_fall, hr_fall;
    logic            pix_byte, pix_in_win, sof;
    logic            ovf_set, geom_set, clr_xy;
    logic [YW-1:0]   y_next;

    assign vs_rise    = vs_q & ~vs_dly_q;
    assign vs_fall    = ~vs_q & vs_dly_q;
    assign hr_fall    = ~hr_q & hr_dly_q;
    assign pix_byte   = hr_q & phase_q;
    assign pix_in_win = pix_byte && (x_q < X_FULL) && (y_q < Y_FULL);
    assign sof        = (x_q == '0) && (y_q == '0);
    // Line count including a line ending in this very cycle, so a frame
    // check coinciding with the last hr falling edge sees the full count.
    assign y_next     = (hr_fall && (y_q != Y_FULL)) ? (y_q + YW'(1)) : y_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        count_d  = count_q;
        ovf_set  = 1'b0;
        geom_set = 1'b0;
        clr_xy   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (vs_fall) begin
                    clr_xy  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pix_in_win) begin
                    if (queue_full) begin
                        ovf_set = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        wr_en_d = 1'b1;
                    end
                end
                if (hr_fall && (x_q != X_FULL)) begin
                    geom_set = 1'b1;
                end
                if (vs_rise) begin
                    state_d = ST_SYNC;
                    // A frame that overflows on its very last cycle is
                    // still a dropped frame: no completion report.
                    if (!(pix_in_win && queue_full)) begin
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                        if (y_next != Y_FULL) begin
                            geom_set = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (vs_rise) begin
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            vs_q     <= 1'b0;
            hr_q     <= 1'b0;
            d_q      <= 8'd0;
            vs_dly_q <= 1'b0;
            hr_dly_q <= 1'b0;
            phase_q  <= 1'b0;
            hi_q     <= 8'd0;
            x_q      <= '0;
            y_q      <= '0;
            data_q   <= 17'd0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 8'd0;
            ovf_q    <= 1'b0;
            geom_q   <= 1'b0;
        end else begin
            vs_q     <= cam_vsync;
            hr_q     <= cam_href;
            d_q      <= p_data;
            vs_dly_q <= vs_q;
            hr_dly_q <= hr_q;

            // Phase restarts every line so an odd trailing byte never
            // pairs with the first byte of the next line.
            phase_q <= hr_q ? ~phase_q : 1'b0;
            if (hr_q && !phase_q) begin
                hi_q <= d_q;
            end

            if (clr_xy || hr_fall) begin
                x_q <= '0;
            end else if (pix_byte && (x_q != X_CAP)) begin
                x_q <= x_q + XW'(1);
            end

            if (clr_xy) begin
                y_q <= '0;
            end else begin
                y_q <= y_next;
            end

            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                data_q <= {sof, hi_q, d_q};
            end
            done_q  <= done_d;
            count_q <= count_d;

            // Setting has priority over a coincident clear.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (err_clear) begin
                ovf_q <= 1'b0;
            end
            if (geom_set) begin
                geom_q <= 1'b1;
            end else if (err_clear) begin
                geom_q <= 1'b0;
            end
        end
    end

    assign queue_data  = data_q;
    assign queue_wr_en = wr_en_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;
    assign overflow    = ovf_q;
    assign geom_error  = geom_q;

endmodule
`default_nettype wire
